// File: rtl/wb_ifetch.sv
// rtl/wb_ifetch.sv - Wishbone instruction fetch master with prefetch FIFO
//
// Fetches word-aligned instructions over a single-outstanding Wishbone read
// interface and buffers {pc, data, err} in a FIFO_DEPTH-entry queue for the core.
// A bus error halts fetching until the next redirect.
// Ports:
//   wb_clk_i, wb_rst_n_i          clock, asynchronous active-low reset
//   redirect_i, redirect_pc_i     flush queue and restart fetch at new pc
//   inst_vld_o/_o/_pc_o/_err_o    queue head; popped when inst_rdy_i is high
//   wb_*                          Wishbone read master (registered outputs)
module wb_ifetch #(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [AW-1:0]   RESET_PC   = '0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          inst_vld_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_err_o,
  input  logic          inst_rdy_i,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] WORD_STEP = AW'(4);
  localparam logic [AW-1:0] ALIGN_M   = ~AW'(3);

  typedef enum logic [1:0] {IDLE, BUS, DRAIN, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          cyc_q, cyc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] fifo_pc_q  [FIFO_DEPTH];
  logic [DW-1:0] fifo_dat_q [FIFO_DEPTH];
  logic          fifo_err_q [FIFO_DEPTH];

  logic          resp;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;

  assign resp = wb_ack_i | wb_err_i;
  // A redirect flushes the queue, so neither a pop nor a push may take effect on that edge.
  assign pop  = (count_q != '0) & inst_rdy_i & ~redirect_i;
  assign push = (state_q == BUS) & resp & ~redirect_i;
  assign count_next = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    case (state_q)
      IDLE: begin
        // Only issue when the response is guaranteed a slot, so a push never overflows.
        if (!redirect_i && (count_next < DEPTH_C)) begin
          state_d = BUS;
          adr_d   = fetch_pc_q;
          cyc_d   = 1'b1;
        end
      end
      BUS: begin
        if (resp) begin
          cyc_d = 1'b0;
          if (redirect_i) begin
            state_d = IDLE;
          end else if (wb_err_i) begin
            state_d = HALT;
          end else begin
            state_d    = IDLE;
            fetch_pc_d = fetch_pc_q + WORD_STEP;
          end
        end else if (redirect_i) begin
          // The slave still owes a response; wait for it and then throw it away.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (resp) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HALT: begin
        if (redirect_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    if (redirect_i) fetch_pc_d = redirect_pc_i & ALIGN_M;

    count_d  = redirect_i ? '0 : count_next;
    rd_ptr_d = redirect_i ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = redirect_i ? '0 : wr_ptr_q + PW'(push);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      adr_q      <= RESET_PC;
      cyc_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= fetch_pc_q;
      fifo_dat_q[wr_ptr_q] <= wb_dat_i;
      fifo_err_q[wr_ptr_q] <= wb_err_i;
    end
  end

  assign inst_vld_o = (count_q != '0);
  assign inst_o     = fifo_dat_q[rd_ptr_q];
  assign inst_pc_o  = fifo_pc_q[rd_ptr_q];
  assign inst_err_o = inst_vld_o & fifo_err_q[rd_ptr_q];

  assign wb_adr_o = adr_q;
  assign wb_dat_o = '0;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = 1'b0;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_ifetch.sv
// tb/tb_wb_ifetch.sv - self-checking bench for wb_ifetch
`timescale 1ns/1ps
module tb_wb_ifetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        rdy = 1'b0;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        vld, inst_err, wb_we, wb_cyc, wb_stb;
  logic [31:0] inst, inst_pc, wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;

  always #5 clk = ~clk;

  wb_ifetch #(.AW(32), .DW(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_vld_o(vld), .inst_o(inst), .inst_pc_o(inst_pc), .inst_err_o(inst_err),
    .inst_rdy_i(rdy),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Slave: responds lat cycles after it first sees stb; err_adr answers with ack and err together.
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] err_adr = 32'hFFFF_FFF0;

  always @(negedge clk) begin
    if (!rst_n || ack || err) begin
      ack = 1'b0; err = 1'b0; wcnt = 0;
    end else if (wb_cyc) begin
      if (wcnt >= lat) begin
        dat_i = rom(wb_adr);
        ack = 1'b1;
        err = (wb_adr == err_adr);
      end else begin
        wcnt++;
      end
    end
  end

  // Reference model: queue of expected entries, next fetch pc, halt and stale-response flags.
  typedef struct packed {logic [31:0] pc; logic [31:0] dat; logic err;} ent_t;
  ent_t        q[$];
  ent_t        pop_log[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] m_pc = '0;
  bit          m_halt = 0;
  bit          m_stale = 0;
  logic        s_cyc = 1'b0;
  logic [31:0] s_adr = '0;
  int          cyc_n = 0;

  always @(posedge clk) begin
    ent_t e;
    cyc_n++;
    if (!rst_n) begin
      q.delete(); m_pc = '0; m_halt = 0; m_stale = 0;
    end else if (redirect) begin
      q.delete();
      m_pc = redirect_pc & ~32'h3;
      m_halt = 0;
      m_stale = s_cyc && !(ack || err);
    end else begin
      if (q.size() > 0 && rdy) pop_log.push_back(q.pop_front());
      if (s_cyc && (ack || err)) begin
        if (m_stale) begin
          m_stale = 0;
        end else begin
          e.pc = s_adr; e.dat = dat_i; e.err = err;
          q.push_back(e);
          if (err) m_halt = 1;
          else m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk_eq("inst_vld", vld, q.size() != 0);
      if (q.size() != 0) begin
        chk_eq("inst_pc", inst_pc, q[0].pc);
        chk_eq("inst_err", inst_err, q[0].err);
        if (!q[0].err) chk_eq("inst_data", inst, q[0].dat);
      end
      chk_eq("cyc_eq_stb", wb_stb, wb_cyc);
      chk_eq("wb_const", {wb_we, wb_sel, wb_dat_o}, {1'b0, 4'hF, 32'h0});
      if (wb_cyc && !s_cyc) begin
        req_log.push_back(wb_adr);
        req_cyc.push_back(cyc_n);
        chk_eq("req_adr", wb_adr, m_pc);
        chk_eq("req_allowed", {m_halt, m_stale, q.size() < DEPTH}, 3'b001);
      end
      if (wb_cyc && s_cyc) chk_eq("adr_stable", wb_adr, s_adr);
    end
    s_cyc = wb_cyc;
    s_adr = wb_adr;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic r);
    rst_n = 1'b0; redirect = 1'b0; rdy = r; lat = l;
    err_adr = 32'hFFFF_FFF0;
    tick(2);
    req_log.delete(); req_cyc.delete(); pop_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input int limit);
    int i = 0;
    while (req_log.size() < n && i < limit) begin tick(1); i++; end
    chk_eq("req_wait", req_log.size() >= n, 1'b1);
  endtask

  task automatic wait_vld(input int limit);
    int i = 0;
    while (!vld && i < limit) begin tick(1); i++; end
    chk_eq("vld_wait", vld, 1'b1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    tick(1);
    redirect = 1'b0;
  endtask

  initial begin
    automatic logic [31:0] exp_w [4] = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C};
    int n;
    int i;
    #3;
    chk_eq("reset_out", {vld, inst_err, wb_cyc, wb_stb, wb_adr}, {4'b0000, 32'h0});

    // Streaming fetch with a zero-wait slave
    do_reset(0, 1'b1);
    tick(1);
    chk_eq("first_stb", {wb_cyc, wb_adr}, {1'b1, 32'h0});
    wait_reqs(4, 20);
    for (int k = 0; k < 4; k++) begin
      chk_eq("t1_adr", req_log[k], 32'(k * 4));
      if (k > 0) chk_eq("t1_stb_period", req_cyc[k] - req_cyc[k-1], 2);
    end
    i = 0;
    while (pop_log.size() < 4 && i < 20) begin tick(1); i++; end
    for (int k = 0; k < 4; k++)
      chk_eq("t1_pop", {pop_log[k].pc, pop_log[k].dat, pop_log[k].err}, {32'(k * 4), exp_w[k], 1'b0});

    // Back-pressure: exactly DEPTH words buffered, then one pop allows one fetch
    do_reset(0, 1'b0);
    tick(20);
    chk_eq("t2_full", {req_log.size() == 4, wb_cyc, vld, inst_pc}, {3'b101, 32'h0});
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    tick(10);
    chk_eq("t2_refill", {req_log.size() == 5, req_log[4], inst_pc}, {1'b1, 32'h10, 32'h4});
    chk_eq("t2_pops", pop_log.size(), 1);

    // Redirect while stb high, response one cycle later is dropped
    do_reset(1, 1'b0);
    tick(1);
    chk_eq("t3_stb", wb_cyc, 1'b1);
    pulse_redirect(32'h103);
    chk_eq("t3_drain", {wb_cyc, vld}, 2'b10);
    tick(1);
    chk_eq("t3_idle", {wb_cyc, vld}, 2'b00);
    wait_reqs(2, 10);
    chk_eq("t3_adr", req_log[1], 32'h100);
    wait_vld(10);
    chk_eq("t3_head", {inst_pc, inst}, {32'h100, 32'hC0DE0100});
    // Redirect on the same edge as the ack
    i = 0;
    while (wb_cyc && i < 20) begin tick(1); i++; end
    while (!wb_cyc && i < 40) begin tick(1); i++; end
    n = req_log.size();
    tick(1);
    pulse_redirect(32'h200);
    chk_eq("t3b_flush", {wb_cyc, vld}, 2'b00);
    wait_reqs(n + 1, 10);
    chk_eq("t3b_adr", req_log[n], 32'h200);
    wait_vld(10);
    chk_eq("t3b_head", inst_pc, 32'h200);

    // Bus error halts fetching until redirect
    do_reset(0, 1'b1);
    err_adr = 32'h8;
    tick(20);
    chk_eq("t4_halt", {req_log.size() == 3, wb_cyc, pop_log.size() == 3}, 3'b101);
    chk_eq("t4_err_entry", {pop_log[2].pc, pop_log[2].err, pop_log[1].err}, {32'h8, 2'b10});
    pulse_redirect(32'h20);
    wait_reqs(4, 10);
    chk_eq("t4_resume", req_log[3], 32'h20);

    // Push and pop on the same edge keep the order intact
    do_reset(1, 1'b0);
    tick(20);
    chk_eq("t5_full", {req_log.size() == 4, vld, inst_pc}, {2'b11, 32'h0});
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    tick(1);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    chk_eq("t5_head", {vld, inst_pc, pop_log.size() == 2}, {1'b1, 32'h8, 1'b1});
    chk_eq("t5_pops", {pop_log[0].pc, pop_log[1].pc}, {32'h0, 32'h4});
    tick(12);
    chk_eq("t5_after", {req_log.size() == 6, req_log[5], inst_pc}, {1'b1, 32'h14, 32'h8});

    // Asynchronous reset mid-transfer
    do_reset(3, 1'b0);
    tick(7);
    chk_eq("t6_pre", {wb_cyc, vld}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_reset", {vld, inst_err, wb_cyc, wb_stb, wb_adr}, {4'b0000, 32'h0});
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk_eq("t6_restart", {wb_cyc, wb_adr}, {1'b1, 32'h0});

    // fetch_pc wraps at the top of the address space
    lat = 0; rdy = 1'b1;
    tick(4);
    n = req_log.size();
    pulse_redirect(32'hFFFF_FFFF);
    wait_reqs(n + 2, 20);
    chk_eq("t7_wrap", {req_log[n], req_log[n+1]}, {32'hFFFF_FFFC, 32'h0});

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
